patch_row_accumulator: RTL and testbench

- Single-clock, camera-link-domain patch row extractor/reducer; successor to the two-row, 4-pixel, 6-wide patch row reducer.
- Takes a multi-lane, multi-row pixel beat stream and picks out PATCH_SIZE consecutive columns of one configured row.
- Per pixel: dark-subtracts with clamp at zero, weights, then accumulates into a saturating sum. The sum is returned with a tag through a valid/ack handshake.
- Sits between the camera-link deserialiser and the patch reducer arbiter, one instance per active patch row.

---
 rtl/patch_row_accumulator.sv | 263 ++++++++++++++++++++++++++
 tb/tb_patch_row_accumulator.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/patch_row_accumulator.sv
// Patch row accumulator.
// Extracts PATCH_SIZE consecutive columns of one configured row from a
// multi-lane, multi-row camera-link beat stream. Each matched pixel is
// dark-subtracted (clamped at zero) and weighted in stage 1. Stage 2 adds
// the lane products into a saturating accumulator. The result is returned
// with its owner tag over a valid/ack handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a configuration, cfg_rdy high
// ACCUM  | matching beats, filling the column mask
// FLUSH1 | last products sitting in the stage-1 registers
// FLUSH2 | accumulator holds the final sum, result raised on next edge
// DONE   | result held until sum_ack
module patch_row_accumulator #(
    parameter int N_LANE      = 4,
    parameter int N_ROW       = 2,
    parameter int PIXEL_SIZE  = 12,
    parameter int WEIGHT_SIZE = 16,
    parameter int PATCH_SIZE  = 6,
    parameter int N_COL_SIZE  = 12,
    parameter int SUM_SIZE    = 32,
    parameter int TAG_SIZE    = 4
) (
    input  logic                                 cl_clk,
    input  logic                                 reset,
    input  logic                                 cfg_valid,
    output logic                                 cfg_rdy,
    input  logic [N_COL_SIZE-1:0]                cfg_start_col,
    input  logic [((N_ROW > 1) ? $clog2(N_ROW) : 1)-1:0] cfg_row,
    input  logic [TAG_SIZE-1:0]                  cfg_tag,
    input  logic [PATCH_SIZE*PIXEL_SIZE-1:0]     cfg_dark,
    input  logic [PATCH_SIZE*WEIGHT_SIZE-1:0]    cfg_weight,
    input  logic                                 pix_valid,
    input  logic [N_COL_SIZE-1:0]                pix_r_col,
    input  logic [$clog2(N_LANE):0]              pix_n,
    input  logic [N_ROW*N_LANE*PIXEL_SIZE-1:0]   pix_data,
    input  logic                                 pix_eol,
    output logic                                 busy,
    output logic                                 sum_valid,
    input  logic                                 sum_ack,
    output logic [SUM_SIZE-1:0]                  sum,
    output logic [TAG_SIZE-1:0]                  sum_tag,
    output logic                                 sum_partial
);

    localparam int ROW_W  = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int CW     = N_COL_SIZE + 1;
    localparam int PROD_W = PIXEL_SIZE + WEIGHT_SIZE;
    localparam int TREE_W = PROD_W + $clog2(N_LANE) + 1;
    localparam int ADD_W  = ((SUM_SIZE > TREE_W) ? SUM_SIZE : TREE_W) + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCUM  = 3'd1;
    localparam logic [2:0] ST_FLUSH1 = 3'd2;
    localparam logic [2:0] ST_FLUSH2 = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    logic [2:0]                       state_q, state_d;
    logic [N_COL_SIZE-1:0]            start_col_q, start_col_d;
    logic [ROW_W-1:0]                 row_q, row_d;
    logic [TAG_SIZE-1:0]              tag_q, tag_d;
    logic [PATCH_SIZE*PIXEL_SIZE-1:0] dark_q, dark_d;
    logic [PATCH_SIZE*WEIGHT_SIZE-1:0] weight_q, weight_d;
    logic [PATCH_SIZE-1:0]            mask_q, mask_d;
    logic                             partial_q, partial_d;
    logic                             sum_valid_q, sum_valid_d;
    logic [SUM_SIZE-1:0]              acc_q, acc_d;
    logic                             sat_q, sat_d;
    logic [PROD_W-1:0]                prod_q [N_LANE];
    logic [PROD_W-1:0]                prod_d [N_LANE];

    logic                             cfg_accept;
    logic                             accum_beat;
    logic [PATCH_SIZE-1:0]            hit_mask;
    logic [CW-1:0]                    lane_col   [N_LANE];
    logic [CW-1:0]                    lane_k     [N_LANE];
    logic [N_LANE-1:0]                lane_ok;
    logic [N_LANE-1:0]                lane_hit;
    logic [PIXEL_SIZE-1:0]            lane_px    [N_LANE];
    logic [PIXEL_SIZE-1:0]            lane_dark  [N_LANE];
    logic [PIXEL_SIZE-1:0]            lane_diff  [N_LANE];
    logic [WEIGHT_SIZE-1:0]           lane_wt    [N_LANE];
    logic [TREE_W-1:0]                tree_sum;
    logic [ADD_W-1:0]                 acc_sum;

    assign cfg_accept = (state_q == ST_IDLE) && cfg_valid;
    assign accum_beat = (state_q == ST_ACCUM) && pix_valid;

    // Lane column and patch index; computed one bit wider so a column left
    // of the patch shows up as negative instead of aliasing into range.
    always_comb begin
        for (int i = 0; i < N_LANE; i++) begin
            lane_col[i] = CW'(pix_r_col) - CW'(i);
            lane_k[i]   = lane_col[i] - CW'(start_col_q);
            lane_ok[i]  = (CW'(i) < CW'(pix_n))
                       && (CW'(i) <= CW'(pix_r_col))
                       && !lane_k[i][CW-1]
                       && (lane_k[i] < CW'(PATCH_SIZE));
        end
    end

    // Row select: pick the configured row's pixel for every lane.
    always_comb begin
        for (int i = 0; i < N_LANE; i++) begin
            lane_px[i] = '0;
            for (int r = 0; r < N_ROW; r++) begin
                if (row_q == ROW_W'(r)) begin
                    lane_px[i] = pix_data[(r*N_LANE+i)*PIXEL_SIZE +: PIXEL_SIZE];
                end
            end
        end
    end

    // Stage 1: match lanes to unfilled patch indices, clamp-subtract and weight.
    always_comb begin
        hit_mask = '0;
        for (int i = 0; i < N_LANE; i++) begin
            lane_hit[i]  = 1'b0;
            lane_dark[i] = '0;
            lane_wt[i]   = '0;
            prod_d[i]    = '0;
            for (int j = 0; j < PATCH_SIZE; j++) begin
                if (accum_beat && lane_ok[i] && (lane_k[i] == CW'(j)) && !mask_q[j]) begin
                    lane_hit[i]  = 1'b1;
                    lane_dark[i] = dark_q[j*PIXEL_SIZE +: PIXEL_SIZE];
                    lane_wt[i]   = weight_q[j*WEIGHT_SIZE +: WEIGHT_SIZE];
                    hit_mask[j]  = 1'b1;
                end
            end
            lane_diff[i] = (lane_px[i] > lane_dark[i]) ? (lane_px[i] - lane_dark[i]) : '0;
            if (lane_hit[i]) begin
                prod_d[i] = PROD_W'(lane_diff[i]) * PROD_W'(lane_wt[i]);
            end
        end
    end

    // Stage 2: reduce the registered lane products (zero for unmatched lanes).
    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < N_LANE; i++) begin
            tree_sum = tree_sum + TREE_W'(prod_q[i]);
        end
    end

    assign acc_sum = ADD_W'(acc_q) + ADD_W'(tree_sum);

    // Saturating accumulator; once clipped it stays at full scale until reconfigured.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (cfg_accept) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (sat_q) begin
            acc_d = '1;
        end else if (|acc_sum[ADD_W-1:SUM_SIZE]) begin
            acc_d = '1;
            sat_d = 1'b1;
        end else begin
            acc_d = acc_sum[SUM_SIZE-1:0];
        end
    end

    // Sequencing FSM, configuration capture and column mask.
    always_comb begin
        state_d     = state_q;
        start_col_d = start_col_q;
        row_d       = row_q;
        tag_d       = tag_q;
        dark_d      = dark_q;
        weight_d    = weight_q;
        mask_d      = mask_q;
        partial_d   = partial_q;
        sum_valid_d = sum_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    start_col_d = cfg_start_col;
                    row_d       = cfg_row;
                    tag_d       = cfg_tag;
                    dark_d      = cfg_dark;
                    weight_d    = cfg_weight;
                    mask_d      = '0;
                    partial_d   = 1'b0;
                    state_d     = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (pix_valid) begin
                    mask_d = mask_q | hit_mask;
                    if (&(mask_q | hit_mask)) begin
                        partial_d = 1'b0;
                        state_d   = ST_FLUSH1;
                    end else if (pix_eol) begin
                        partial_d = 1'b1;
                        state_d   = ST_FLUSH1;
                    end
                end
            end
            ST_FLUSH1: begin
                state_d = ST_FLUSH2;
            end
            ST_FLUSH2: begin
                state_d     = ST_DONE;
                sum_valid_d = 1'b1;
            end
            ST_DONE: begin
                if (sum_ack) begin
                    state_d     = ST_IDLE;
                    sum_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                sum_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any work in flight.
    always_ff @(posedge cl_clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_col_q <= '0;
            row_q       <= '0;
            tag_q       <= '0;
            dark_q      <= '0;
            weight_q    <= '0;
            mask_q      <= '0;
            partial_q   <= 1'b0;
            sum_valid_q <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            for (int i = 0; i < N_LANE; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            start_col_q <= start_col_d;
            row_q       <= row_d;
            tag_q       <= tag_d;
            dark_q      <= dark_d;
            weight_q    <= weight_d;
            mask_q      <= mask_d;
            partial_q   <= partial_d;
            sum_valid_q <= sum_valid_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            for (int i = 0; i < N_LANE; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    assign cfg_rdy     = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign sum_valid   = sum_valid_q;
    assign sum         = acc_q;
    assign sum_tag     = tag_q;
    assign sum_partial = partial_q;

endmodule

// File: tb/tb_patch_row_accumulator.sv
// Directed bench for patch_row_accumulator: a default instance plus a
// 16-bit accumulator instance sharing the same stimulus.
`timescale 1ns/1ps
module tb_patch_row_accumulator;

    localparam int N_LANE = 4;
    localparam int N_ROW  = 2;
    localparam int PIX    = 12;
    localparam int WT     = 16;
    localparam int PATCH  = 6;
    localparam int NCOL   = 12;

    logic                          cl_clk = 1'b0;
    logic                          reset  = 1'b1;
    logic                          cfg_valid;
    logic [NCOL-1:0]               cfg_start_col;
    logic [0:0]                    cfg_row;
    logic [3:0]                    cfg_tag;
    logic [PATCH*PIX-1:0]          cfg_dark;
    logic [PATCH*WT-1:0]           cfg_weight;
    logic                          pix_valid;
    logic [NCOL-1:0]               pix_r_col;
    logic [2:0]                    pix_n;
    logic [N_ROW*N_LANE*PIX-1:0]   pix_data;
    logic                          pix_eol;
    logic                          sum_ack;

    logic        cfg_rdy, busy, sum_valid, sum_partial;
    logic [31:0] sum;
    logic [3:0]  sum_tag;
    logic        s_cfg_rdy, s_busy, s_sum_valid, s_sum_partial;
    logic [15:0] s_sum;
    logic [3:0]  s_sum_tag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 cl_clk = ~cl_clk;

    patch_row_accumulator u_dut (
        .cl_clk(cl_clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_rdy(cfg_rdy), .cfg_start_col(cfg_start_col),
        .cfg_row(cfg_row), .cfg_tag(cfg_tag), .cfg_dark(cfg_dark), .cfg_weight(cfg_weight),
        .pix_valid(pix_valid), .pix_r_col(pix_r_col), .pix_n(pix_n), .pix_data(pix_data),
        .pix_eol(pix_eol), .busy(busy), .sum_valid(sum_valid), .sum_ack(sum_ack),
        .sum(sum), .sum_tag(sum_tag), .sum_partial(sum_partial)
    );

    patch_row_accumulator #(.SUM_SIZE(16)) u_sat (
        .cl_clk(cl_clk), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_rdy(s_cfg_rdy), .cfg_start_col(cfg_start_col),
        .cfg_row(cfg_row), .cfg_tag(cfg_tag), .cfg_dark(cfg_dark), .cfg_weight(cfg_weight),
        .pix_valid(pix_valid), .pix_r_col(pix_r_col), .pix_n(pix_n), .pix_data(pix_data),
        .pix_eol(pix_eol), .busy(s_busy), .sum_valid(s_sum_valid), .sum_ack(sum_ack),
        .sum(s_sum), .sum_tag(s_sum_tag), .sum_partial(s_sum_partial)
    );

    task automatic fill_dark(input int v);
        for (int k = 0; k < PATCH; k++) cfg_dark[k*PIX +: PIX] = v[PIX-1:0];
    endtask

    task automatic fill_weight(input int v);
        for (int k = 0; k < PATCH; k++) cfg_weight[k*WT +: WT] = v[WT-1:0];
    endtask

    task automatic put_pix(input int r, input int lane, input int v);
        pix_data[(r*N_LANE+lane)*PIX +: PIX] = v[PIX-1:0];
    endtask

    task automatic fill_row(input int r, input int v);
        for (int l = 0; l < N_LANE; l++) put_pix(r, l, v);
    endtask

    task automatic do_cfg(input int start, input int row, input int tag);
        cfg_start_col = start[NCOL-1:0];
        cfg_row       = row[0:0];
        cfg_tag       = tag[3:0];
        cfg_valid     = 1'b1;
        @(negedge cl_clk);
        cfg_valid     = 1'b0;
    endtask

    task automatic send_beat(input int rcol, input int n, input logic eol);
        pix_r_col = rcol[NCOL-1:0];
        pix_n     = n[2:0];
        pix_eol   = eol;
        pix_valid = 1'b1;
        @(negedge cl_clk);
        pix_valid = 1'b0;
        pix_eol   = 1'b0;
    endtask

    task automatic do_ack();
        sum_ack = 1'b1;
        @(negedge cl_clk);
        sum_ack = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge cl_clk);
        reset = 1'b0;
        @(negedge cl_clk);
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL rst_sum_valid: got %0b expected 0", sum_valid); end
        n_cmp++; if (sum !== 32'd0) begin n_bad++; $display("FAIL rst_sum: got %0d expected 0", sum); end
        n_cmp++; if (sum_tag !== 4'd0) begin n_bad++; $display("FAIL rst_tag: got %0d expected 0", sum_tag); end
        n_cmp++; if (sum_partial !== 1'b0) begin n_bad++; $display("FAIL rst_partial: got %0b expected 0", sum_partial); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_cmp++; if (cfg_rdy !== 1'b1) begin n_bad++; $display("FAIL rst_cfg_rdy: got %0b expected 1", cfg_rdy); end
    endtask

    task automatic test_basic();
        fill_dark(100);
        fill_weight(1);
        do_cfg(10, 0, 10);
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %0b expected 1", busy); end
        // matching data with pix_valid low must not count
        fill_row(0, 4000);
        pix_r_col = 12'd11; pix_n = 3'd4;
        @(negedge cl_clk);
        fill_row(0, 200);
        send_beat(11, 4, 1'b0);
        // stray ack while accumulating
        do_ack();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_stray_ack: busy got %0b expected 1", busy); end
        send_beat(15, 4, 1'b0);
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat1: got %0b expected 0", sum_valid); end
        @(negedge cl_clk);
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL basic_lat2: got %0b expected 0", sum_valid); end
        @(negedge cl_clk);
        n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL basic_lat3: got %0b expected 1", sum_valid); end
        n_cmp++; if (sum !== 32'd600) begin n_bad++; $display("FAIL basic_sum: got %0d expected 600", sum); end
        n_cmp++; if (sum_partial !== 1'b0) begin n_bad++; $display("FAIL basic_partial: got %0b expected 0", sum_partial); end
        n_cmp++; if (sum_tag !== 4'd10) begin n_bad++; $display("FAIL basic_tag: got %0d expected 10", sum_tag); end
        n_cmp++; if (cfg_rdy !== 1'b0) begin n_bad++; $display("FAIL basic_done_rdy: got %0b expected 0", cfg_rdy); end
        @(negedge cl_clk);
        n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL basic_hold: got %0b expected 1", sum_valid); end
        do_ack();
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL basic_ack: got %0b expected 0", sum_valid); end
        n_cmp++; if (cfg_rdy !== 1'b1) begin n_bad++; $display("FAIL basic_ack_rdy: got %0b expected 1", cfg_rdy); end
        n_cmp++; if (sum !== 32'd600) begin n_bad++; $display("FAIL basic_sum_kept: got %0d expected 600", sum); end
    endtask

    task automatic test_row_select();
        fill_dark(100);
        fill_weight(7);
        do_cfg(20, 1, 3);
        fill_row(0, 4000);
        fill_row(1, 110);
        put_pix(1, 1, 50);
        send_beat(23, 4, 1'b0);
        fill_row(1, 110);
        put_pix(1, 2, 0);
        put_pix(1, 3, 0);
        send_beat(25, 2, 1'b0);
        repeat (2) @(negedge cl_clk);
        n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL row_valid: got %0b expected 1", sum_valid); end
        n_cmp++; if (sum !== 32'd350) begin n_bad++; $display("FAIL row_sum: got %0d expected 350", sum); end
        n_cmp++; if (sum_tag !== 4'd3) begin n_bad++; $display("FAIL row_tag: got %0d expected 3", sum_tag); end
        do_ack();
    endtask

    task automatic test_partial();
        fill_dark(30);
        fill_weight(2);
        do_cfg(4092, 0, 7);
        fill_row(0, 31);
        fill_row(1, 0);
        send_beat(4095, 4, 1'b1);
        repeat (2) @(negedge cl_clk);
        n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL part_valid: got %0b expected 1", sum_valid); end
        n_cmp++; if (sum !== 32'd8) begin n_bad++; $display("FAIL part_sum: got %0d expected 8", sum); end
        n_cmp++; if (sum_partial !== 1'b1) begin n_bad++; $display("FAIL part_flag: got %0b expected 1", sum_partial); end
        n_cmp++; if (sum_tag !== 4'd7) begin n_bad++; $display("FAIL part_tag: got %0d expected 7", sum_tag); end
        do_ack();
    endtask

    task automatic test_no_wrap();
        // lanes 2,3 of r_col=1 would alias to 4095/4094 if columns wrapped
        fill_dark(0);
        fill_weight(1);
        do_cfg(4090, 0, 2);
        fill_row(0, 1000);
        send_beat(1, 4, 1'b1);
        repeat (2) @(negedge cl_clk);
        n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL wrap_valid: got %0b expected 1", sum_valid); end
        n_cmp++; if (sum !== 32'd0) begin n_bad++; $display("FAIL wrap_sum: got %0d expected 0", sum); end
        n_cmp++; if (sum_partial !== 1'b1) begin n_bad++; $display("FAIL wrap_partial: got %0b expected 1", sum_partial); end
        do_ack();
    endtask

    task automatic test_saturation();
        fill_dark(0);
        fill_weight(65535);
        do_cfg(0, 0, 1);
        fill_row(0, 4095);
        send_beat(3, 4, 1'b0);
        send_beat(5, 2, 1'b0);
        repeat (2) @(negedge cl_clk);
        n_cmp++; if (s_sum_valid !== 1'b1) begin n_bad++; $display("FAIL sat_valid: got %0b expected 1", s_sum_valid); end
        n_cmp++; if (s_sum !== 16'hFFFF) begin n_bad++; $display("FAIL sat_sum16: got %0h expected ffff", s_sum); end
        n_cmp++; if (s_sum_partial !== 1'b0) begin n_bad++; $display("FAIL sat_partial: got %0b expected 0", s_sum_partial); end
        n_cmp++; if (sum !== 32'd1610194950) begin n_bad++; $display("FAIL sat_sum32: got %0d expected 1610194950", sum); end
        do_ack();
    endtask

    task automatic test_back_to_back();
        fill_dark(0);
        fill_weight(1);
        do_cfg(10, 0, 9);
        fill_row(0, 0);
        put_pix(0, 0, 5); put_pix(0, 1, 6); put_pix(0, 2, 7);
        send_beat(12, 3, 1'b0);
        // column 12 again with a new value: already filled, ignored
        put_pix(0, 0, 1000);
        send_beat(12, 1, 1'b0);
        put_pix(0, 0, 8); put_pix(0, 1, 9); put_pix(0, 2, 10);
        send_beat(15, 3, 1'b0);
        fill_row(0, 500);
        send_beat(16, 4, 1'b0);
        @(negedge cl_clk);
        n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid: got %0b expected 1", sum_valid); end
        n_cmp++; if (sum !== 32'd45) begin n_bad++; $display("FAIL b2b_sum: got %0d expected 45", sum); end
        send_beat(13, 4, 1'b1);
        n_cmp++; if (sum !== 32'd45) begin n_bad++; $display("FAIL b2b_done_beat: got %0d expected 45", sum); end
        n_cmp++; if (sum_partial !== 1'b0) begin n_bad++; $display("FAIL b2b_partial: got %0b expected 0", sum_partial); end
        // ack and a new config in the same DONE cycle
        cfg_start_col = 12'd100;
        cfg_row       = 1'b0;
        cfg_tag       = 4'd5;
        cfg_valid     = 1'b1;
        sum_ack       = 1'b1;
        #1;
        n_cmp++; if (cfg_rdy !== 1'b0) begin n_bad++; $display("FAIL b2b_rdy_in_done: got %0b expected 0", cfg_rdy); end
        @(negedge cl_clk);
        sum_ack = 1'b0;
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_ack: got %0b expected 0", sum_valid); end
        n_cmp++; if (cfg_rdy !== 1'b1) begin n_bad++; $display("FAIL b2b_rdy_after: got %0b expected 1", cfg_rdy); end
        n_cmp++; if (sum_tag !== 4'd9) begin n_bad++; $display("FAIL b2b_tag_old: got %0d expected 9", sum_tag); end
        n_cmp++; if (sum !== 32'd45) begin n_bad++; $display("FAIL b2b_sum_kept: got %0d expected 45", sum); end
        @(negedge cl_clk);
        cfg_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy: got %0b expected 1", busy); end
        n_cmp++; if (sum_tag !== 4'd5) begin n_bad++; $display("FAIL b2b_tag_new: got %0d expected 5", sum_tag); end
        n_cmp++; if (sum !== 32'd0) begin n_bad++; $display("FAIL b2b_sum_clear: got %0d expected 0", sum); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        @(negedge cl_clk);
        reset = 1'b0;
        fill_dark(10);
        fill_weight(3);
        do_cfg(50, 0, 6);
        fill_row(0, 0);
        put_pix(0, 0, 22); put_pix(0, 1, 21); put_pix(0, 2, 20);
        send_beat(52, 3, 1'b0);
        @(negedge cl_clk);
        n_cmp++; if (sum !== 32'd99) begin n_bad++; $display("FAIL mid_partial_sum: got %0d expected 99", sum); end
        reset = 1'b1;
        #1;
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %0b expected 0", sum_valid); end
        n_cmp++; if (cfg_rdy !== 1'b1) begin n_bad++; $display("FAIL mid_rst_rdy: got %0b expected 1", cfg_rdy); end
        n_cmp++; if (sum !== 32'd0) begin n_bad++; $display("FAIL mid_rst_sum: got %0d expected 0", sum); end
        @(negedge cl_clk);
        reset = 1'b0;
        do_cfg(50, 0, 6);
        put_pix(0, 0, 22); put_pix(0, 1, 21); put_pix(0, 2, 20);
        send_beat(52, 3, 1'b0);
        put_pix(0, 0, 25); put_pix(0, 1, 24); put_pix(0, 2, 23);
        send_beat(55, 3, 1'b0);
        repeat (2) @(negedge cl_clk);
        n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL mid_valid: got %0b expected 1", sum_valid); end
        n_cmp++; if (sum !== 32'd225) begin n_bad++; $display("FAIL mid_sum: got %0d expected 225", sum); end
        n_cmp++; if (sum_tag !== 4'd6) begin n_bad++; $display("FAIL mid_tag: got %0d expected 6", sum_tag); end
        do_ack();
    endtask

    initial begin
        cfg_valid     = 1'b0;
        cfg_start_col = '0;
        cfg_row       = '0;
        cfg_tag       = '0;
        cfg_dark      = '0;
        cfg_weight    = '0;
        pix_valid     = 1'b0;
        pix_r_col     = '0;
        pix_n         = '0;
        pix_data      = '0;
        pix_eol       = 1'b0;
        sum_ack       = 1'b0;
        test_reset();
        test_basic();
        test_row_select();
        test_partial();
        test_no_wrap();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
